// File: rtl/btb_pkg.sv
// Shared types for the BTB write scheduler: write kinds, the queued request
// record and the default geometry.
package btb_pkg;

  localparam int BTB_INDEX_BITS = 2;
  localparam int BTB_TAG_BITS   = 28;

  typedef enum logic [1:0] {
    WR_INIT   = 2'd0,
    WR_ALLOC  = 2'd1,
    WR_UPDATE = 2'd2
  } btb_wr_kind_t;

  typedef struct packed {
    btb_wr_kind_t                kind;
    logic [BTB_INDEX_BITS-1:0]   index;
    logic [BTB_TAG_BITS-1:0]     tag;
    logic                        taken;
    logic [31:0]                 target;
  } btb_req_t;

endpackage

// File: rtl/btb_req_fifo.sv
// Two-push / one-pop circular request queue. When both pushes fire, data0
// is the older entry; push1 is only used together with push0. The caller
// guarantees it never overflows or pops empty.
module btb_req_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_sys,
  input  logic          rst_b,
  input  logic          push0,
  input  btb_req_t      data0,
  input  logic          push1,
  input  btb_req_t      data1,
  input  logic          pop,
  output btb_req_t      head,
  output logic [CW-1:0] count
);

  btb_req_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // storage: the second push lands in the slot after the first
  always_ff @(posedge clk_sys) begin
    if (push0) mem[wr_ptr] <= data0;
    if (push1) mem[wr_ptr + AW'(1)] <= data1;
  end

  // pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/btb_update_scheduler.sv
// Serializes BTB writes (init sweep, decode allocations, execute updates)
// onto a single write port, oldest first.
// Optional feature macro: BTB_UPDATE_SCHED_BYPASS_EN -- with an empty queue
// and a ready write port, the oldest incoming request goes straight to the
// port in the same cycle instead of through the queue.
//
// state   | meaning
// ST_INIT | sweeping every entry to invalid/strong-not-taken, upstream stalled
// ST_RUN  | normal traffic queued and drained in age order
module btb_update_scheduler
  import btb_pkg::*;
#(
  parameter int INDEX_BITS = BTB_INDEX_BITS,
  parameter int TAG_BITS   = BTB_TAG_BITS,
  parameter int DEPTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alloc_valid,
  input  logic [INDEX_BITS-1:0] i_alloc_index,
  input  logic [TAG_BITS-1:0]   i_alloc_tag,
  input  logic                  i_upd_valid,
  input  logic [INDEX_BITS-1:0] i_upd_index,
  input  logic [TAG_BITS-1:0]   i_upd_tag,
  input  logic                  i_upd_taken,
  input  logic [31:0]           i_upd_target,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_wr_valid,
  input  logic                  i_wr_ready,
  output logic [1:0]            o_wr_kind,
  output logic [INDEX_BITS-1:0] o_wr_index,
  output logic [TAG_BITS-1:0]   o_wr_tag,
  output logic                  o_wr_taken,
  output logic [31:0]           o_wr_target,
  output logic                  o_init_done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [INDEX_BITS-1:0] LAST_INDEX = {INDEX_BITS{1'b1}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state, state_nxt;
  logic [INDEX_BITS-1:0] sweep_cnt, sweep_nxt;
  logic                  push0, push1, pop;
  btb_req_t              d0, d1, head, wr_req, upd_req, alc_req;
  logic [CW-1:0]         fifo_count;
  logic                  stall, wr_valid, upd_v, alc_v;

  btb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys (i_clk),
    .rst_b   (i_rst),
    .push0   (push0),
    .data0   (d0),
    .push1   (push1),
    .data1   (d1),
    .pop     (pop),
    .head    (head),
    .count   (fifo_count)
  );

  // state and sweep counter registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_nxt;
    end
  end

  // format the two incoming requests as queue records
  always_comb begin
    upd_req        = '0;
    upd_req.kind   = WR_UPDATE;
    upd_req.index  = i_upd_index;
    upd_req.tag    = i_upd_tag;
    upd_req.taken  = i_upd_taken;
    upd_req.target = i_upd_target;
    alc_req        = '0;
    alc_req.kind   = WR_ALLOC;
    alc_req.index  = i_alloc_index;
    alc_req.tag    = i_alloc_tag;
    upd_v          = i_upd_valid;
    alc_v          = i_alloc_valid & ~i_flush;
  end

  // next state, push/pop control and write-port selection
  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_cnt;
    stall     = 1'b1;
    wr_valid  = 1'b0;
    wr_req    = '0;
    push0     = 1'b0;
    push1     = 1'b0;
    pop       = 1'b0;
    d0        = '0;
    d1        = '0;
    case (state)
      ST_INIT: begin
        wr_valid     = 1'b1;
        wr_req.kind  = WR_INIT;
        wr_req.index = sweep_cnt;
        if (i_wr_ready) begin
          if (sweep_cnt == LAST_INDEX) state_nxt = ST_RUN;
          else                         sweep_nxt = sweep_cnt + INDEX_BITS'(1);
        end
      end
      ST_RUN: begin
        // two free slots are always kept so a double push never overflows
        stall = (fifo_count > CW'(DEPTH - 2));
        if (fifo_count != '0) begin
          wr_valid = 1'b1;
          wr_req   = head;
          pop      = i_wr_ready;
        end
        if (!stall) begin
          // the update belongs to the older instruction, so it goes first
          if (upd_v) begin
            d0    = upd_req;
            push0 = 1'b1;
            if (alc_v) begin
              d1    = alc_req;
              push1 = 1'b1;
            end
          end else if (alc_v) begin
            d0    = alc_req;
            push0 = 1'b1;
          end
`ifdef BTB_UPDATE_SCHED_BYPASS_EN
          if (fifo_count == '0 && i_wr_ready && push0) begin
            wr_valid = 1'b1;
            wr_req   = d0;
            push0    = push1;
            d0       = d1;
            push1    = 1'b0;
            d1       = '0;
          end
`endif
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign o_stall     = stall;
  assign o_wr_valid  = wr_valid;
  assign o_wr_kind   = wr_req.kind;
  assign o_wr_index  = wr_req.index;
  assign o_wr_tag    = wr_req.tag;
  assign o_wr_taken  = wr_req.taken;
  assign o_wr_target = wr_req.target;
  assign o_init_done = (state == ST_RUN);

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Randomized scoreboard bench for btb_update_scheduler. The driver records
// every accepted request as an expected write in age order; the monitor
// pops and compares on each write-port handshake.
module tb_btb_update_scheduler;

  localparam int DEPTH  = 4;
  localparam int NITER  = 400;
  localparam int RST_AT = 200;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_alloc_valid, i_upd_valid, i_upd_taken, i_flush, i_wr_ready;
  logic [1:0]  i_alloc_index, i_upd_index;
  logic [27:0] i_alloc_tag, i_upd_tag;
  logic [31:0] i_upd_target;
  logic        o_stall, o_wr_valid, o_wr_taken, o_init_done;
  logic [1:0]  o_wr_kind, o_wr_index;
  logic [27:0] o_wr_tag;
  logic [31:0] o_wr_target;

  btb_update_scheduler #(.INDEX_BITS(2), .TAG_BITS(28), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_alloc_valid(i_alloc_valid), .i_alloc_index(i_alloc_index), .i_alloc_tag(i_alloc_tag),
    .i_upd_valid(i_upd_valid), .i_upd_index(i_upd_index), .i_upd_tag(i_upd_tag),
    .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target), .i_flush(i_flush),
    .o_stall(o_stall), .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
    .o_wr_kind(o_wr_kind), .o_wr_index(o_wr_index), .o_wr_tag(o_wr_tag),
    .o_wr_taken(o_wr_taken), .o_wr_target(o_wr_target), .o_init_done(o_init_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  kind;
    logic [1:0]  index;
    logic [27:0] tag;
    logic        taken;
    logic [31:0] target;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   init_seen = 0;
  int   byp_cyc = -10;

  always @(posedge i_clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model of a reset: queue forgotten, full sweep expected again
  task automatic model_reset();
    exp_t e;
    sb.delete();
    init_seen = 0;
    for (int i = 0; i < 4; i++) begin
      e = '{kind: 2'd0, index: 2'(i), tag: '0, taken: 1'b0, target: '0, acc: -1};
      sb.push_back(e);
    end
  endtask

  task automatic new_req();
    i_upd_valid   = ($urandom_range(0, 1) == 1);
    i_upd_index   = 2'($urandom);
    i_upd_tag     = 28'($urandom);
    i_upd_taken   = 1'($urandom);
    i_upd_target  = $urandom;
    i_alloc_valid = ($urandom_range(0, 1) == 1);
    i_alloc_index = 2'($urandom);
    i_alloc_tag   = 28'($urandom);
    i_flush       = ($urandom_range(0, 4) == 0);
  endtask

  // record what the scheduler is required to write for this cycle's inputs
  task automatic accept();
    exp_t e;
    if (i_upd_valid) begin
      e = '{kind: 2'd2, index: i_upd_index, tag: i_upd_tag, taken: i_upd_taken,
            target: i_upd_target, acc: cyc};
      sb.push_back(e);
    end
    if (i_alloc_valid && !i_flush) begin
      e = '{kind: 2'd1, index: i_alloc_index, tag: i_alloc_tag, taken: 1'b0,
            target: '0, acc: cyc};
      sb.push_back(e);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_stall"}, 64'(o_stall), 64'd1);
    check({tag, "_init_done"}, 64'(o_init_done), 64'd0);
    check({tag, "_wr_valid"}, 64'(o_wr_valid), 64'd1);
    check({tag, "_wr_kind"}, 64'(o_wr_kind), 64'd0);
    check({tag, "_wr_index"}, 64'(o_wr_index), 64'd0);
    check({tag, "_wr_tag"}, 64'(o_wr_tag), 64'd0);
  endtask

  // driver: holds a stalled request until accepted, randomizes ready
  initial begin
    logic hold;
    logic exp_stall;
    hold = 1'b0;
    i_rst = 1'b1;
    i_alloc_valid = 0; i_alloc_index = 0; i_alloc_tag = 0;
    i_upd_valid = 0; i_upd_index = 0; i_upd_tag = 0; i_upd_taken = 0;
    i_upd_target = 0; i_flush = 0; i_wr_ready = 0;
    #1 i_rst = 1'b0;
    #2 reset_checks("reset");
    model_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    i_wr_ready = 1'b1;
    // first request: same-cycle alloc and update, held through the sweep
    i_upd_valid = 1; i_upd_index = 2; i_upd_tag = 28'h123_4567; i_upd_taken = 1;
    i_upd_target = 32'h0000_0040;
    i_alloc_valid = 1; i_alloc_index = 1; i_alloc_tag = 28'h000_0ABC; i_flush = 0;
    hold = 1'b1;
    for (int n = 0; n < NITER; n++) begin
      if (!hold) new_req();
      if (n >= 6) begin
        if (n >= RST_AT - 8 && n < RST_AT) i_wr_ready = 1'b0;
        else                               i_wr_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge i_clk);
      exp_stall = (init_seen < 4) || (sb.size() > DEPTH - 2);
      check("stall", 64'(o_stall), 64'(exp_stall));
      if (!o_stall) begin
`ifdef BTB_UPDATE_SCHED_BYPASS_EN
        if (sb.size() == 0 && i_wr_ready && (i_upd_valid || (i_alloc_valid && !i_flush)))
          byp_cyc = cyc;
`endif
        accept();
        hold = 1'b0;
      end else begin
        hold = 1'b1;
      end
      @(posedge i_clk); #1;
      if (n == RST_AT) begin
        i_rst = 1'b0;
        i_wr_ready = 1'b0;
        i_upd_valid = 0; i_alloc_valid = 0;
        model_reset();
        #2 reset_checks("midrst");
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        i_wr_ready = 1'b1;
        hold = 1'b0;
      end
    end
    i_upd_valid = 0; i_alloc_valid = 0; i_wr_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge i_clk);
    @(negedge i_clk); #4;
    check("drain_left", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // monitor: compares every handshake against the oldest expected write
  initial begin
    exp_t e;
    logic        have_prev;
    logic [66:0] prev, cur;
    have_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge i_clk); #2;
      if (!i_rst) begin
        have_prev = 1'b0;
        continue;
      end
      cur = {o_wr_kind, o_wr_index, o_wr_tag, o_wr_taken, o_wr_target, o_wr_valid, 1'b0};
      check("init_done", 64'(o_init_done), 64'(init_seen >= 4));
      if (have_prev) check("hold_stable", 64'(cur[66:1]), 64'(prev[66:1]));
      if (byp_cyc == cyc) check("bypass_same_cycle", 64'(o_wr_valid), 64'd1);
      if (o_wr_valid && i_wr_ready) begin
        if (sb.size() == 0) begin
          check("spurious_write", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("wr_kind", 64'(o_wr_kind), 64'(e.kind));
          check("wr_index", 64'(o_wr_index), 64'(e.index));
          check("wr_tag", 64'(o_wr_tag), 64'(e.tag));
          check("wr_taken", 64'(o_wr_taken), 64'(e.taken));
          check("wr_target", 64'(o_wr_target), 64'(e.target));
`ifndef BTB_UPDATE_SCHED_BYPASS_EN
          if (e.acc >= 0) check("min_latency", 64'(cyc > e.acc), 64'd1);
`endif
          if (e.kind == 2'd0) init_seen++;
        end
      end else if (!o_wr_valid) begin
        check("idle_zero", 64'({o_wr_kind, o_wr_index, o_wr_taken} | 64'(o_wr_tag) | 64'(o_wr_target)), 64'd0);
      end
      have_prev = o_wr_valid && !i_wr_ready;
      prev = cur;
    end
  end

endmodule
